// File: rtl/freelist_ckpt_pkg.sv
// rtl/freelist_ckpt_pkg.sv - shared sizing constants for the checkpointed rename free list
package freelist_ckpt_pkg;
    localparam int PHY_REG_NUM = 64;
    localparam int PHY_REG_SEL = $clog2(PHY_REG_NUM);
    localparam int FL_ALLOC_W  = 2;
    localparam int FL_REL_W    = 2;
    localparam int FL_CKPT_NUM = 4;
    localparam int CKPT_SEL    = $clog2(FL_CKPT_NUM);
endpackage

// File: rtl/freelist_ckpt_pick_first_n.sv
// rtl/freelist_ckpt_pick_first_n.sv - returns the N lowest set-bit indices of a vector with valids
module pick_first_n #(
    parameter int W  = 64,
    parameter int N  = 2,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]    vec_i,
    output logic [N*IW-1:0] idx_o,
    output logic [N-1:0]    valid_o
);
    logic [W-1:0] rem;
    logic         found;

    // Each pass takes the lowest remaining bit and removes it for the next pass.
    always_comb begin
        rem     = vec_i;
        idx_o   = '0;
        valid_o = '0;
        found   = 1'b0;
        for (int n = 0; n < N; n++) begin
            found = 1'b0;
            for (int i = 0; i < W; i++) begin
                if (rem[i] && !found) begin
                    idx_o[n*IW +: IW] = IW'(i);
                    valid_o[n]        = 1'b1;
                    found             = 1'b1;
                    rem[i]            = 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/freelist_ckpt.sv
// rtl/freelist_ckpt.sv - rename free list with branch checkpoints; FREELIST_DFREE_CHECK_EN adds double-free detection
module freelist_ckpt #(
    parameter int PHY_REG_NUM = freelist_ckpt_pkg::PHY_REG_NUM,
    parameter int ALLOC_W     = freelist_ckpt_pkg::FL_ALLOC_W,
    parameter int REL_W       = freelist_ckpt_pkg::FL_REL_W,
    parameter int CKPT_NUM    = freelist_ckpt_pkg::FL_CKPT_NUM
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [ALLOC_W-1:0]                   alloc_req,
    input  logic                                 stall_DP,
    output logic [ALLOC_W*$clog2(PHY_REG_NUM)-1:0] phy_dst,
    output logic [ALLOC_W-1:0]                   phy_dst_valid,
    output logic                                 allocatable,
    input  logic [REL_W*$clog2(PHY_REG_NUM)-1:0] released_tag,
    input  logic [REL_W-1:0]                     released_tag_valid,
    input  logic                                 ckpt_take,
    output logic [$clog2(CKPT_NUM)-1:0]          ckpt_id,
    output logic                                 ckpt_avail,
    input  logic                                 ckpt_release,
    input  logic [$clog2(CKPT_NUM)-1:0]          ckpt_release_id,
    input  logic                                 prmiss,
    input  logic [$clog2(CKPT_NUM)-1:0]          prmiss_id,
    output logic [$clog2(PHY_REG_NUM):0]         freenum,
    output logic                                 err_double_free
);
    import freelist_ckpt_pkg::*;

    localparam int TW = $clog2(PHY_REG_NUM);
    localparam int CS = $clog2(CKPT_NUM);
    localparam int CW = TW + 1;

    logic [PHY_REG_NUM-1:0]                   free_q, free_d;
    logic [CW-1:0]                            freenum_q, freenum_d;
    logic [CKPT_NUM-1:0]                      valid_q, valid_d;
    logic [CKPT_NUM-1:0][PHY_REG_NUM-1:0]     snap_q, snap_d;
    logic [CKPT_NUM-1:0][CW-1:0]              snapn_q, snapn_d;
    logic [CKPT_NUM-1:0][CKPT_NUM-1:0]        age_q, age_d;

    logic [ALLOC_W*TW-1:0]    cand;
    logic [ALLOC_W-1:0]       cand_valid;
    logic [0:0]               ckpt_pick_valid;
    logic [PHY_REG_NUM-1:0]   grant_mask;
    logic [PHY_REG_NUM-1:0]   rel_vec;
    logic [CW-1:0]            alloc_cnt;
    logic [CW-1:0]            rel_cnt;
    logic                     fire;
    logic                     take;
    int                       r;

    pick_first_n #(.W(PHY_REG_NUM), .N(ALLOC_W), .IW(TW)) u_grant_pick (
        .vec_i   (free_q),
        .idx_o   (cand),
        .valid_o (cand_valid)
    );

    pick_first_n #(.W(CKPT_NUM), .N(1), .IW(CS)) u_ckpt_pick (
        .vec_i   (~valid_q),
        .idx_o   (ckpt_id),
        .valid_o (ckpt_pick_valid)
    );

    assign ckpt_avail  = ckpt_pick_valid[0];
    assign alloc_cnt   = CW'($countones(alloc_req));
    assign allocatable = (freenum_q >= alloc_cnt);
    assign fire        = allocatable & ~stall_DP & ~prmiss & (|alloc_req);
    assign take        = ckpt_take & ckpt_avail & fire;
    assign freenum     = freenum_q;

    // The n-th requesting lane takes the n-th candidate; the mask is what fire removes.
    always_comb begin
        phy_dst       = '0;
        phy_dst_valid = '0;
        grant_mask    = '0;
        r             = 0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_req[i]) begin
                phy_dst[i*TW +: TW] = cand[r*TW +: TW];
                phy_dst_valid[i]    = allocatable & cand_valid[r];
                if (allocatable)
                    grant_mask[cand[r*TW +: TW]] = 1'b1;
                r = r + 1;
            end
        end
    end

    always_comb begin
        rel_vec = '0;
        for (int j = 0; j < REL_W; j++)
            if (released_tag_valid[j])
                rel_vec[released_tag[j*TW +: TW]] = 1'b1;
    end

`ifdef FREELIST_DFREE_CHECK_EN
    logic err_q;
    logic dfree_hit;

    // Only newly freed bits count; a shortfall against the valid lanes means a double free.
    assign rel_cnt         = CW'($countones(rel_vec & ~free_q));
    assign dfree_hit       = (CW'($countones(released_tag_valid)) != rel_cnt);
    assign err_double_free = err_q;

    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= err_q | dfree_hit;
    end
`else
    assign rel_cnt         = CW'($countones(released_tag_valid));
    assign err_double_free = 1'b0;
`endif

    always_comb begin
        free_d    = free_q;
        freenum_d = freenum_q + rel_cnt;
        if (fire) begin
            free_d    = free_d & ~grant_mask;
            freenum_d = freenum_d - alloc_cnt;
        end
        free_d = free_d | rel_vec;
        if (prmiss) begin
            free_d    = snap_q[prmiss_id] | rel_vec;
            freenum_d = snapn_q[prmiss_id] + rel_cnt;
        end
    end

    // age_q[s][t] = 1: slot s was taken while t was live, so s is younger than t.
    always_comb begin
        valid_d = valid_q;
        snap_d  = snap_q;
        snapn_d = snapn_q;
        age_d   = age_q;
        for (int s = 0; s < CKPT_NUM; s++) begin
            if (valid_q[s]) begin
                snap_d[s]  = snap_q[s] | rel_vec;
                snapn_d[s] = snapn_q[s] + rel_cnt;
            end
        end
        if (ckpt_release)
            valid_d[ckpt_release_id] = 1'b0;
        if (take) begin
            valid_d[ckpt_id] = 1'b1;
            snap_d[ckpt_id]  = free_d;
            snapn_d[ckpt_id] = freenum_d;
            for (int t = 0; t < CKPT_NUM; t++) begin
                age_d[ckpt_id][t] = valid_q[t] && (CS'(t) != ckpt_id);
                age_d[t][ckpt_id] = 1'b0;
            end
        end
        if (prmiss) begin
            for (int s = 0; s < CKPT_NUM; s++)
                if ((CS'(s) == prmiss_id) || age_q[s][prmiss_id])
                    valid_d[s] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            free_q    <= '1;
            freenum_q <= CW'(PHY_REG_NUM);
            valid_q   <= '0;
            snap_q    <= '0;
            snapn_q   <= '0;
            age_q     <= '0;
        end else begin
            free_q    <= free_d;
            freenum_q <= freenum_d;
            valid_q   <= valid_d;
            snap_q    <= snap_d;
            snapn_q   <= snapn_d;
            age_q     <= age_d;
        end
    end
endmodule
